// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - write/read port bundle for the multiport register file
interface regfile_multiport_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int N_RD   = 2,
    parameter int N_WR   = 2
);
    logic [N_WR-1:0]        wr_en;
    logic [N_WR*ADDR_W-1:0] wr_addr;
    logic [N_WR*DATA_W-1:0] wr_data;
    logic [N_RD-1:0]        rd_en;
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic [N_RD-1:0]        rd_valid;
    logic [N_RD-1:0]        rd_written;
    logic                   wr_conflict;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_written, wr_conflict
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, rd_written, wr_conflict
    );
endinterface

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-read/multi-write register file with per-entry written bits
module regfile_multiport #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int N_RD      = 2,
    parameter int N_WR      = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 0
) (
    input logic                clk,
    input logic                rst,
    regfile_multiport_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [DATA_W-1:0]      mem_d [DEPTH];
    logic [DEPTH-1:0]       written_q, written_d;
    logic [N_WR-1:0]        wr_eff;
    logic [N_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [N_RD-1:0]        rd_written_q, rd_written_d;
    logic [N_RD-1:0]        rd_valid_q;
    logic                   wr_conflict_q, wr_conflict_d;

    // Effective write enables: writes to a hard-wired zero entry are dropped entirely
    always_comb begin
        for (int p = 0; p < N_WR; p++) begin
            wr_eff[p] = rf.wr_en[p] &&
                        !((ZERO_REG0 != 0) && (rf.wr_addr[p*ADDR_W +: ADDR_W] == '0));
        end
    end

    // Post-write array image; ascending port order lets the highest index win
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        written_d = written_q;
        for (int p = 0; p < N_WR; p++) begin
            if (wr_eff[p]) begin
                mem_d[rf.wr_addr[p*ADDR_W +: ADDR_W]]     = rf.wr_data[p*DATA_W +: DATA_W];
                written_d[rf.wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    // Flag any pair of effective writes aimed at the same entry
    always_comb begin
        wr_conflict_d = 1'b0;
        for (int p = 0; p < N_WR; p++) begin
            for (int q = p + 1; q < N_WR; q++) begin
                if (wr_eff[p] && wr_eff[q] &&
                    (rf.wr_addr[p*ADDR_W +: ADDR_W] == rf.wr_addr[q*ADDR_W +: ADDR_W])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // Read lanes: write-through reads see the post-write image, read-old sees current state
    always_comb begin
        rd_data_d    = rd_data_q;
        rd_written_d = rd_written_q;
        for (int r = 0; r < N_RD; r++) begin
            if (rf.rd_en[r]) begin
                if ((ZERO_REG0 != 0) && (rf.rd_addr[r*ADDR_W +: ADDR_W] == '0)) begin
                    rd_data_d[r*DATA_W +: DATA_W] = '0;
                    rd_written_d[r]               = 1'b1;
                end else if (BYPASS != 0) begin
                    rd_data_d[r*DATA_W +: DATA_W] = mem_d[rf.rd_addr[r*ADDR_W +: ADDR_W]];
                    rd_written_d[r]               = written_d[rf.rd_addr[r*ADDR_W +: ADDR_W]];
                end else begin
                    rd_data_d[r*DATA_W +: DATA_W] = mem_q[rf.rd_addr[r*ADDR_W +: ADDR_W]];
                    rd_written_d[r]               = written_q[rf.rd_addr[r*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    // State update; reset discards any same-cycle requests
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q     <= '0;
            rd_data_q     <= '0;
            rd_written_q  <= '0;
            rd_valid_q    <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            written_q     <= written_d;
            rd_data_q     <= rd_data_d;
            rd_written_q  <= rd_written_d;
            rd_valid_q    <= rf.rd_en;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign rf.rd_data     = rd_data_q;
    assign rf.rd_written  = rd_written_q;
    assign rf.rd_valid    = rd_valid_q;
    assign rf.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - scoreboard bench for two regfile_multiport configurations
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_multiport_if #(.DATA_W(16), .ADDR_W(3), .N_RD(2), .N_WR(2)) if_a ();
    regfile_multiport_if #(.DATA_W(16), .ADDR_W(3), .N_RD(2), .N_WR(2)) if_b ();

    regfile_multiport #(
        .DATA_W(16), .ADDR_W(3), .N_RD(2), .N_WR(2), .BYPASS(1), .ZERO_REG0(0)
    ) dut_a (.clk(clk), .rst(rst), .rf(if_a));

    regfile_multiport #(
        .DATA_W(16), .ADDR_W(3), .N_RD(2), .N_WR(2), .BYPASS(0), .ZERO_REG0(1)
    ) dut_b (.clk(clk), .rst(rst), .rf(if_b));

    typedef struct {
        int          cfg;
        int          lane;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    string       kind_name[4] = '{"data", "written", "valid", "conflict"};

    logic [15:0] m_mem [2][8];
    logic        m_wrt [2][8];
    logic [15:0] m_data[2][2];
    logic        m_w   [2][2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] observe(input int cfg, input int lane, input int kind);
        logic [31:0] d;
        logic [1:0]  v;
        logic [1:0]  w;
        logic        c;
        if (cfg == 0) begin
            d = if_a.rd_data; v = if_a.rd_valid; w = if_a.rd_written; c = if_a.wr_conflict;
        end else begin
            d = if_b.rd_data; v = if_b.rd_valid; w = if_b.rd_written; c = if_b.wr_conflict;
        end
        case (kind)
            0:       return d[lane*16 +: 16];
            1:       return {15'd0, w[lane]};
            2:       return {15'd0, v[lane]};
            default: return {15'd0, c};
        endcase
    endfunction

    function automatic void push(input int cfg, input int lane, input int kind, input logic [15:0] exp);
        exp_t e;
        e.cfg = cfg; e.lane = lane; e.kind = kind; e.exp = exp;
        sb.push_back(e);
    endfunction

    // One clock: drive, predict both configurations, advance, compare everything queued
    task automatic step(input logic r, input logic [1:0] we,
                        input logic [2:0] wa0, input logic [15:0] wd0,
                        input logic [2:0] wa1, input logic [15:0] wd1,
                        input logic [1:0] re, input logic [2:0] ra0, input logic [2:0] ra1);
        logic [2:0]  wa[2];
        logic [15:0] wd[2];
        logic [2:0]  ra[2];
        logic [15:0] d;
        logic        w;
        logic        v;
        logic        conf;
        bit          byp;
        bit          zero;
        exp_t        e;
        wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
        rst = r;
        if_a.wr_en = we; if_a.wr_addr = {wa1, wa0}; if_a.wr_data = {wd1, wd0};
        if_a.rd_en = re; if_a.rd_addr = {ra1, ra0};
        if_b.wr_en = we; if_b.wr_addr = {wa1, wa0}; if_b.wr_data = {wd1, wd0};
        if_b.rd_en = re; if_b.rd_addr = {ra1, ra0};
        for (int c = 0; c < 2; c++) begin
            byp  = (c == 0);
            zero = (c == 1);
            for (int l = 0; l < 2; l++) begin
                v = 1'b0;
                if (r) begin
                    m_data[c][l] = 16'h0;
                    m_w[c][l]    = 1'b0;
                end else if (re[l]) begin
                    v = 1'b1;
                    if (zero && ra[l] == 3'd0) begin
                        d = 16'h0; w = 1'b1;
                    end else begin
                        d = m_mem[c][ra[l]]; w = m_wrt[c][ra[l]];
                        if (byp) begin
                            for (int p = 0; p < 2; p++) begin
                                if (we[p] && !(zero && wa[p] == 3'd0) && wa[p] == ra[l]) begin
                                    d = wd[p]; w = 1'b1;
                                end
                            end
                        end
                    end
                    m_data[c][l] = d;
                    m_w[c][l]    = w;
                end
                push(c, l, 0, m_data[c][l]);
                push(c, l, 1, {15'd0, m_w[c][l]});
                push(c, l, 2, {15'd0, v});
            end
            conf = !r && (we == 2'b11) && (wa0 == wa1) && !(zero && wa0 == 3'd0);
            push(c, 0, 3, {15'd0, conf});
            for (int i = 0; i < 8; i++) begin
                if (r) begin
                    m_mem[c][i] = 16'h0;
                    m_wrt[c][i] = 1'b0;
                end
            end
            if (!r) begin
                for (int p = 0; p < 2; p++) begin
                    if (we[p] && !(zero && wa[p] == 3'd0)) begin
                        m_mem[c][wa[p]] = wd[p];
                        m_wrt[c][wa[p]] = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq($sformatf("cfg%0d_lane%0d_%s", e.cfg, e.lane, kind_name[e.kind]),
                     {16'd0, observe(e.cfg, e.lane, e.kind)}, {16'd0, e.exp});
        end
    endtask

    initial begin
        rst = 1'b1;
        if_a.wr_en = '0; if_a.wr_addr = '0; if_a.wr_data = '0; if_a.rd_en = '0; if_a.rd_addr = '0;
        if_b.wr_en = '0; if_b.wr_addr = '0; if_b.wr_data = '0; if_b.rd_en = '0; if_b.rd_addr = '0;
        step(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0);
        // Post-reset read of 2 and 5
        step(0, 2'b00, 0, 0, 0, 0, 2'b11, 3'd2, 3'd5);
        // Single write then read on the other port
        step(0, 2'b01, 3'd3, 16'hBEEF, 0, 0, 2'b00, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 3'd3);
        // Same-address dual write, port 1 wins
        step(0, 2'b11, 3'd6, 16'h1111, 3'd6, 16'h2222, 2'b00, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 2'b11, 3'd6, 3'd6);
        // Same-cycle write/read of addr 4
        step(0, 2'b01, 3'd4, 16'h00AA, 0, 0, 2'b00, 0, 0);
        step(0, 2'b01, 3'd4, 16'h0055, 0, 0, 2'b01, 3'd4, 0);
        step(0, 2'b00, 0, 0, 0, 0, 2'b01, 3'd4, 0);
        // Writes to addr 0 from both ports, then read and same-cycle read
        step(0, 2'b11, 3'd0, 16'hFFFF, 3'd0, 16'h0001, 2'b10, 0, 3'd0);
        step(0, 2'b00, 0, 0, 0, 0, 2'b11, 3'd0, 3'd0);
        // Reset swallows a concurrent write
        step(0, 2'b01, 3'd1, 16'h7777, 0, 0, 2'b00, 0, 0);
        step(1, 2'b01, 3'd1, 16'h1234, 0, 0, 2'b11, 3'd1, 3'd1);
        step(0, 2'b00, 0, 0, 0, 0, 2'b11, 3'd1, 3'd3);
        step(0, 2'b01, 3'd2, 16'hCAFE, 0, 0, 2'b00, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 2'b01, 3'd2, 0);
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        // Random traffic with occasional reset
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 19) == 0),
                 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 16'($urandom),
                 3'($urandom_range(0, 7)), 16'($urandom),
                 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of each register in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning address width; depth is DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter N_RD, default 2, meaning number of independent read ports.
REQ-004 SHALL have parameter N_WR, default 2, meaning number of independent write ports.
REQ-005 SHALL have parameter BYPASS, default 1, meaning same-cycle read/write behaviour: 1 = write-through (new data), 0 = read-old.
REQ-006 SHALL have parameter ZERO_REG0, default 0, meaning that when set, entry 0 is hard-wired to zero.
REQ-007 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port wr_en, input, N_WR bits: per-port write request.
REQ-010 SHALL have port wr_addr, input, N_WR*ADDR_W bits: port p address in bits [p*ADDR_W +: ADDR_W].
REQ-011 SHALL have port wr_data, input, N_WR*DATA_W bits: port p data in bits [p*DATA_W +: DATA_W].
REQ-012 SHALL have port rd_en, input, N_RD bits: per-port read request.
REQ-013 SHALL have port rd_addr, input, N_RD*ADDR_W bits: packed per read port, same scheme as wr_addr.
REQ-014 SHALL have port rd_data, output, N_RD*DATA_W bits: registered read data, packed per port.
REQ-015 SHALL have port rd_valid, output, N_RD bits: high for one cycle when the matching rd_data lane was updated.
REQ-016 SHALL have port rd_written, output, N_RD bits: registered; entry read had been written since reset.
REQ-017 SHALL have port wr_conflict, output, 1 bit: registered; two or more enabled write ports targeted the same address in the previous cycle.

Function
REQ-018 SHALL commit each enabled write at the rising edge where wr_en[p]=1; data is visible to reads from the next cycle onward.
REQ-019 SHALL resolve same-address multi-port writes by highest port index wins; wr_conflict=1 in the following cycle, else 0.
REQ-020 SHALL keep a per-entry written bit, cleared by reset, set by any committed write.
REQ-021 SHALL have read latency of exactly one cycle: rd_en[r]=1 at edge N gives rd_data lane r, rd_written[r] and rd_valid[r]=1 after edge N.
REQ-022 SHALL hold rd_data and rd_written lanes unchanged while rd_en[r]=0; rd_valid[r]=0 in that cycle.
REQ-023 SHALL, with BYPASS=1, return the winning same-cycle write data (and rd_written=1) when rd_addr matches an enabled wr_addr.
REQ-024 SHALL, with BYPASS=0, return the pre-write contents and pre-write written bit on such a match.
REQ-025 SHALL allow all read ports to read any address, including the same one, in the same cycle without interference.
REQ-026 SHALL, with ZERO_REG0=1, ignore writes to address 0 (no conflict flagged for them, no bypass); reads of address 0 return 0 with rd_written=1.
REQ-027 SHALL perform no operation, and change no state, when all wr_en and rd_en bits are 0.

Reset
REQ-028 SHALL, while rst=1 at a rising edge, clear all entries to 0, all written bits, rd_data, rd_valid, rd_written and wr_conflict to 0.
REQ-029 SHALL give rst priority over every same-cycle write and read; those requests are discarded, not deferred.
REQ-030 SHALL accept new requests on the first edge after rst deasserts.

Verification
REQ-031 Defaults, after reset: rd_en=11, rd_addr={5,2} -> rd_data=0,0; rd_valid=11; rd_written=00.
REQ-032 Write port0 addr3 data 0xBEEF, next cycle read port1 addr3 -> rd_data lane1=0xBEEF, rd_written[1]=1, wr_conflict=0.
REQ-033 Same cycle: port0 writes addr6=0x1111, port1 writes addr6=0x2222 -> wr_conflict=1 next cycle; later read of addr6=0x2222.
REQ-034 Addr4 holds 0x00AA; same cycle write addr4=0x0055 and read addr4 -> BYPASS=1: 0x0055; BYPASS=0: 0x00AA, then 0x0055 on the next read.
REQ-035 ZERO_REG0=1: write addr0=0xFFFF then read addr0 -> rd_data=0, rd_written=1.
REQ-036 rst=1 in the same cycle as a write addr1=0x1234 -> next read addr1 returns 0 with rd_written=0; rd_data held through idle cycles.
